// File: rtl/map_store.sv
// Tile map for the snake game: a 2-bit cell per tile, cleared after reset, with a
// two-stage write path, a forwarded game-side read port and a committed-only display port.
module map_store #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update_wenable,
  input  logic [1:0] update_wdata,
  input  logic [9:0] update_wx,
  input  logic [9:0] update_wy,
  input  logic       update_renable,
  input  logic [9:0] update_rx,
  input  logic [9:0] update_ry,
  output logic [1:0] update_rdata,
  output logic       update_rvalid,
  input  logic [9:0] vga_x,
  input  logic [9:0] vga_y,
  output logic [1:0] vga_rdata,
  output logic       ready,
  output logic [10:0] cobra_count
);

  localparam int              CELLS      = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int              AW         = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [9:0]      W_LIM      = 10'(MAPA_WIDTH);
  localparam logic [9:0]      H_LIM      = 10'(MAPA_HEIGHT);
  localparam logic [AW-1:0]   LAST_ADDR  = AW'(CELLS - 1);
  localparam logic [1:0]      TILE_EMPTY = 2'b00;
  localparam logic [1:0]      TILE_SNAKE = 2'b01;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr;
  logic [1:0]    mem [CELLS];
  logic          run;

  logic          wr_vld_p0, wr_vld_p1;
  logic [AW-1:0] wr_addr_p0, wr_addr_p1;
  logic [1:0]    wr_data_p1;
  logic [1:0]    wr_old_p0, wr_old_p1;
  logic [AW-1:0] rd_addr_p0;
  logic [1:0]    rd_data_p0;
  logic [AW-1:0] vga_addr_p0;
  logic [1:0]    vga_data_p0;

  function automatic logic in_map(input logic [9:0] x, input logic [9:0] y);
    return (x < W_LIM) && (y < H_LIM);
  endfunction

  function automatic logic [AW-1:0] tile_addr(input logic [9:0] x, input logic [9:0] y);
    logic [20:0] a;
    a = 21'(y) * 21'(MAPA_WIDTH) + 21'(x);
    return a[AW-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: if (clr_addr == LAST_ADDR) state_d = RUN;
      RUN:   state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLEAR;
      clr_addr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_addr <= clr_addr + 1'b1;
    end
  end

  assign run   = (state_q == RUN);
  assign ready = run;

  // p0: accept write and fetch old value; service game-side and display reads
  assign wr_addr_p0  = tile_addr(update_wx, update_wy);
  assign wr_vld_p0   = run && update_wenable && in_map(update_wx, update_wy);
  assign wr_old_p0   = (wr_vld_p1 && (wr_addr_p1 == wr_addr_p0)) ? wr_data_p1 : mem[wr_addr_p0];
  assign rd_addr_p0  = tile_addr(update_rx, update_ry);
  assign vga_addr_p0 = tile_addr(vga_x, vga_y);
  assign vga_data_p0 = in_map(vga_x, vga_y) ? mem[vga_addr_p0] : TILE_EMPTY;

  // The newest value wins: this cycle's accept, then the write committing now, then storage.
  always_comb begin
    rd_data_p0 = TILE_EMPTY;
    if (in_map(update_rx, update_ry)) begin
      if (wr_vld_p0 && (wr_addr_p0 == rd_addr_p0))
        rd_data_p0 = update_wdata;
      else if (wr_vld_p1 && (wr_addr_p1 == rd_addr_p0))
        rd_data_p0 = wr_data_p1;
      else
        rd_data_p0 = mem[rd_addr_p0];
    end
  end

  always_ff @(posedge clk) begin
    wr_addr_p1 <= wr_addr_p0;
    wr_data_p1 <= update_wdata;
    wr_old_p1  <= wr_old_p0;
  end

  // p1: commit the cell, adjust the snake count, register read results
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_vld_p1     <= 1'b0;
      update_rvalid <= 1'b0;
      update_rdata  <= TILE_EMPTY;
      vga_rdata     <= TILE_EMPTY;
      cobra_count   <= '0;
    end else begin
      wr_vld_p1     <= wr_vld_p0;
      update_rvalid <= run && update_renable;
      update_rdata  <= run ? rd_data_p0 : TILE_EMPTY;
      vga_rdata     <= run ? vga_data_p0 : TILE_EMPTY;
      if (wr_vld_p1) begin
        if ((wr_old_p1 != TILE_SNAKE) && (wr_data_p1 == TILE_SNAKE))
          cobra_count <= cobra_count + 11'd1;
        else if ((wr_old_p1 == TILE_SNAKE) && (wr_data_p1 != TILE_SNAKE))
          cobra_count <= cobra_count - 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR)
        mem[clr_addr] <= TILE_EMPTY;
      else if (wr_vld_p1)
        mem[wr_addr_p1] <= wr_data_p1;
    end
  end

endmodule

// File: doc/map_store.md
MAP_STORE -- requirements
Module: map_store

Interface
REQ-001 Parameter MAPA_WIDTH, default 40, map width in tiles.
REQ-002 Parameter MAPA_HEIGHT, default 30, map height in tiles.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 update_wenable  input  1  write request, one tile per asserted cycle.
REQ-006 update_wdata  input  2  tile code: 00 empty, 01 snake, 10 fruit, 11 obstacle.
REQ-007 update_wx / update_wy  input  10 each  write tile column / row.
REQ-008 update_renable  input  1  game-side read request.
REQ-009 update_rx / update_ry  input  10 each  game-side read column / row.
REQ-010 update_rdata  output  2  game-side read data.
REQ-011 update_rvalid  output  1  one-cycle pulse qualifying update_rdata.
REQ-012 vga_x / vga_y  input  10 each  display-side read column / row, sampled every cycle.
REQ-013 vga_rdata  output  2  display-side tile code.
REQ-014 ready  output  1  high once the clear sequence has finished.
REQ-015 cobra_count  output  11  number of tiles currently holding 01.

Function
REQ-016 Storage SHALL be MAPA_WIDTH*MAPA_HEIGHT 2-bit cells, address = y*MAPA_WIDTH + x.
REQ-017 FSM SHALL have exactly two states: CLEAR and RUN.
REQ-018 CLEAR SHALL write 00 to one address per cycle, ascending from 0; after writing the last address it SHALL enter RUN next cycle, and ready SHALL rise in that same cycle.
REQ-019 A full clear SHALL take exactly MAPA_WIDTH*MAPA_HEIGHT cycles (1200 at defaults).
REQ-020 In CLEAR, update_wenable and update_renable SHALL be ignored, update_rvalid SHALL stay 0, vga_rdata SHALL be 00.
REQ-021 RUN writes SHALL be two-stage: cycle N accepts address/data and fetches the old value; cycle N+1 commits the cell and updates cobra_count.
REQ-022 Writes with wx >= MAPA_WIDTH or wy >= MAPA_HEIGHT SHALL be dropped with no effect.
REQ-023 Commit SHALL increment cobra_count when old != 01 and new == 01, and decrement it when old == 01 and new != 01; otherwise the count SHALL be unchanged.
REQ-024 Back-to-back writes to the same cell SHALL use the first write's data as the second write's old value (forwarding), so cobra_count stays exact.
REQ-025 update_rdata/update_rvalid SHALL appear exactly one cycle after update_renable.
REQ-026 A read SHALL return the newest value: a commit or accept to the same cell in the read cycle SHALL be forwarded.
REQ-027 Out-of-range reads SHALL return 00 with update_rvalid still pulsed.
REQ-028 vga_rdata SHALL be registered with one-cycle latency, SHALL reflect committed contents only (no forwarding), and SHALL be 00 for out-of-range coordinates.
REQ-029 A simultaneous game-side read, display-side read and write SHALL all be serviced in the same cycle; there SHALL be no stalls and no backpressure.
REQ-030 cobra_count SHALL never wrap; it is bounded by the cell count by construction.

Reset
REQ-031 reset SHALL force CLEAR with the clear address at 0, including mid-clear or mid-write; any pending uncommitted write SHALL be discarded.
REQ-032 Reset values: ready 0, update_rvalid 0, update_rdata 00, vga_rdata 00, cobra_count 0.
REQ-033 Cell contents SHALL be defined only after the clear completes.

Verification
REQ-034 Release reset, idle -> ready rises exactly 1200 cycles later; a scan of all 1200 tiles via vga returns 00.
REQ-035 Write (10,10)=01, then the next cycle renable (10,10) -> update_rdata 01 with rvalid one cycle after renable; cobra_count goes 0->1 one cycle after the write.
REQ-036 Consecutive writes (5,5)=01, (5,5)=01, (5,5)=00 -> cobra_count sequence 1,1,0; no double count.
REQ-037 Write (40,3)=01 and (3,30)=11 -> no cell changes, cobra_count 0; read (40,3) -> 00 with rvalid.
REQ-038 Assert reset for one cycle at clear address 600, then release -> clear restarts at 0 and ready rises 1200 cycles later.
REQ-039 Write (13,13)=10 while vga reads (13,13) the same cycle -> vga_rdata 00 the next cycle, 10 once the write has committed.
